// File: rtl/sar_guess_ctrl_pkg.sv
// Shared types and encodings for the binary-search guess controller.
package sar_guess_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEPW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Decoded comparator answer, one-hot {lt, gt, eq}
  localparam logic [2:0] ANS_NONE = 3'b000;
  localparam logic [2:0] ANS_LT   = 3'b100;
  localparam logic [2:0] ANS_GT   = 3'b010;
  localparam logic [2:0] ANS_EQ   = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] a);
    return (a == ANS_LT) || (a == ANS_GT) || (a == ANS_EQ);
  endfunction

endpackage

// File: rtl/sar_bound_update.sv
// Next-bound and next-guess computation for one accepted lt/gt answer,
// plus detection of answers that leave an empty search interval.
module sar_bound_update
  import sar_guess_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] guess_i,
  input  logic [2:0]       ans_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] guess_o,
  output logic             incons_o
);

  localparam logic [WIDTH-1:0] MAXV  = '1;
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

  logic [WIDTH:0] lo_w;
  logic [WIDTH:0] hi_w;
  logic [WIDTH:0] sum_w;

  always_comb begin
    lo_w     = {1'b0, lo_i};
    hi_w     = {1'b0, hi_i};
    incons_o = 1'b0;
    if (ans_i == ANS_LT) begin
      lo_w     = {1'b0, guess_i} + ONE_W;
      incons_o = (guess_i == MAXV);
    end else if (ans_i == ANS_GT) begin
      // guess=0 wraps hi to all-ones, so the empty range is flagged explicitly
      hi_w     = {1'b0, guess_i} - ONE_W;
      incons_o = (guess_i == '0);
    end
    if (lo_w > hi_w) incons_o = 1'b1;
    sum_w   = lo_w + hi_w;
    lo_o    = lo_w[WIDTH-1:0];
    hi_o    = hi_w[WIDTH-1:0];
    guess_o = WIDTH'(sum_w >> 1);
  end

endmodule

// File: rtl/sar_guess_ctrl.sv
// Binary-search controller driving a magnitude comparator.
// Optional macro SAR_ONEHOT_CHECK_EN: non-one-hot comparator answers go to ERR.
//
// state | meaning
// IDLE  | after reset, waiting for start
// PROBE | guess presented, waiting for a comparator answer
// DONE  | eq received, found/steps valid until next start
// ERR   | answers were inconsistent (or malformed), waiting for start
module sar_guess_ctrl
  import sar_guess_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  input  logic             cmp_valid,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             done,
  output logic [WIDTH-1:0] found,
  output logic [STEPW-1:0] steps,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAXV       = '1;
  localparam logic [WIDTH-1:0] INIT_GUESS = MAXV >> 1;
  localparam logic [STEPW-1:0] STEP_ONE   = STEPW'(1);
  localparam logic [STEPW-1:0] STEP_MAX   = '1;

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_t           state_q;
  logic [WIDTH-1:0] lo_q, hi_q, guess_q, found_q;
  logic [STEPW-1:0] steps_q;
  logic             gv_q, done_q, err_q;

  logic [2:0]       ans_raw;
  logic [2:0]       ans_d;
  logic             take_d;
  logic             bad_d;
  logic [STEPW-1:0] steps_d;
  logic [WIDTH-1:0] lo_d, hi_d, guess_d;
  logic             incons_d;

  assign ans_raw = {cmp_lt, cmp_gt, cmp_eq};

  always_comb begin
    ans_d  = ANS_NONE;
    take_d = 1'b0;
    bad_d  = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
    if (cmp_valid) begin
      take_d = 1'b1;
      if (is_onehot3(ans_raw)) ans_d = ans_raw;
      else                     bad_d = 1'b1;
    end
`else
    if (cmp_valid && ans_raw != ANS_NONE) begin
      take_d = 1'b1;
      if (cmp_eq)      ans_d = ANS_EQ;
      else if (cmp_lt) ans_d = ANS_LT;
      else             ans_d = ANS_GT;
    end
`endif
  end

  assign steps_d = (steps_q == STEP_MAX) ? steps_q : steps_q + STEP_ONE;

  sar_bound_update #(.WIDTH(WIDTH)) u_bound (
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .guess_i  (guess_q),
    .ans_i    (ans_d),
    .lo_o     (lo_d),
    .hi_o     (hi_d),
    .guess_o  (guess_d),
    .incons_o (incons_d)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= MAXV;
      guess_q <= '0;
      steps_q <= '0;
      found_q <= '0;
      gv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        PROBE: begin
          if (take_d) begin
            steps_q <= steps_d;
            if (bad_d) begin
              state_q <= ERR;
              gv_q    <= 1'b0;
              err_q   <= 1'b1;
            end else if (ans_d == ANS_EQ) begin
              state_q <= DONE;
              found_q <= guess_q;
              gv_q    <= 1'b0;
              done_q  <= 1'b1;
            end else if (incons_d) begin
              state_q <= ERR;
              gv_q    <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              lo_q    <= lo_d;
              hi_q    <= hi_d;
              guess_q <= guess_d;
            end
          end
        end
        default: begin
          if (start) begin
            state_q <= PROBE;
            lo_q    <= '0;
            hi_q    <= MAXV;
            guess_q <= INIT_GUESS;
            steps_q <= '0;
            gv_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign guess       = guess_q;
  assign guess_valid = gv_q;
  assign done        = done_q;
  assign found       = found_q;
  assign steps       = steps_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sar_guess_ctrl.sv
// Directed bench for sar_guess_ctrl (WIDTH=4) with a behavioural comparator.
module tb_sar_guess_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] guess;
  logic       guess_valid;
  logic       cmp_valid, cmp_lt, cmp_gt, cmp_eq;
  logic       done;
  logic [3:0] found;
  logic [2:0] steps;
  logic       err;

  logic [3:0] secret = 4'd0;
  int         mode = 0;          // 0 honest, 1 always lt, 2 forced pattern
  logic [2:0] force_pat = 3'b000;
  logic       cmp_en = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sar_guess_ctrl #(.WIDTH(4), .STEPW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .cmp_valid   (cmp_valid),
    .cmp_lt      (cmp_lt),
    .cmp_gt      (cmp_gt),
    .cmp_eq      (cmp_eq),
    .done        (done),
    .found       (found),
    .steps       (steps),
    .err         (err)
  );

  always_comb begin
    cmp_valid = cmp_en;
    cmp_lt    = 1'b0;
    cmp_gt    = 1'b0;
    cmp_eq    = 1'b0;
    if (mode == 1) begin
      cmp_lt = 1'b1;
    end else if (mode == 2) begin
      {cmp_lt, cmp_gt, cmp_eq} = force_pat;
    end else begin
      cmp_lt = guess < secret;
      cmp_gt = guess > secret;
      cmp_eq = guess == secret;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (guess_valid !== 1'b0 || guess !== 4'd0 || steps !== 3'd0 ||
        done !== 1'b0 || err !== 1'b0 || found !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got gv=%b guess=%0d steps=%0d done=%b err=%b found=%0d, want all 0",
               guess_valid, guess, steps, done, err, found);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (guess_valid !== 1'b0 || guess !== 4'd0 || steps !== 3'd0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got gv=%b guess=%0d steps=%0d done=%b err=%b, want all 0",
               guess_valid, guess, steps, done, err);
    end
  endtask

  task automatic test_secret11();
    int g[2] = '{7, 11};
    mode = 0; secret = 4'd11;
    do_start();
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (guess_valid !== 1'b1 || guess !== 4'(g[i])) begin
        errors++;
        $display("FAIL s11_guess%0d: got gv=%b guess=%0d, want gv=1 guess=%0d", i, guess_valid, guess, g[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || found !== 4'd11 || steps !== 3'd2 || err !== 1'b0 || guess_valid !== 1'b0) begin
      errors++;
      $display("FAIL s11_result: got done=%b found=%0d steps=%0d err=%b gv=%b, want 1 11 2 0 0",
               done, found, steps, err, guess_valid);
    end
  endtask

  // start is held high through part of this search; PROBE must ignore it
  task automatic test_secret0();
    int g[4] = '{7, 3, 1, 0};
    mode = 0; secret = 4'd0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == 1 || i == 2);
      checks++;
      if (guess_valid !== 1'b1 || guess !== 4'(g[i])) begin
        errors++;
        $display("FAIL s0_guess%0d: got gv=%b guess=%0d, want gv=1 guess=%0d", i, guess_valid, guess, g[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || found !== 4'd0 || steps !== 3'd4 || err !== 1'b0) begin
      errors++;
      $display("FAIL s0_result: got done=%b found=%0d steps=%0d err=%b, want 1 0 4 0",
               done, found, steps, err);
    end
  endtask

  task automatic test_secret15();
    int g[5] = '{7, 11, 13, 14, 15};
    mode = 0; secret = 4'd15;
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (guess_valid !== 1'b1 || guess !== 4'(g[i])) begin
        errors++;
        $display("FAIL s15_guess%0d: got gv=%b guess=%0d, want gv=1 guess=%0d", i, guess_valid, guess, g[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || found !== 4'd15 || steps !== 3'd5 || err !== 1'b0 || guess_valid !== 1'b0) begin
      errors++;
      $display("FAIL s15_result: got done=%b found=%0d steps=%0d err=%b gv=%b, want 1 15 5 0 0",
               done, found, steps, err, guess_valid);
    end
  endtask

  // Restart straight out of DONE
  task automatic test_back_to_back();
    mode = 0; secret = 4'd3;
    do_start();
    checks++;
    if (guess_valid !== 1'b1 || guess !== 4'd7 || steps !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got gv=%b guess=%0d steps=%0d done=%b, want 1 7 0 0",
               guess_valid, guess, steps, done);
    end
    @(negedge clk);
    checks++;
    if (guess !== 4'd3) begin
      errors++;
      $display("FAIL b2b_guess1: got guess=%0d, want 3", guess);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || found !== 4'd3 || steps !== 3'd2) begin
      errors++;
      $display("FAIL b2b_result: got done=%b found=%0d steps=%0d, want 1 3 2", done, found, steps);
    end
  endtask

  task automatic test_always_lt();
    int g[5] = '{7, 11, 13, 14, 15};
    mode = 1;
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (guess_valid !== 1'b1 || guess !== 4'(g[i])) begin
        errors++;
        $display("FAIL lt_guess%0d: got gv=%b guess=%0d, want gv=1 guess=%0d", i, guess_valid, guess, g[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || steps !== 3'd5 || guess_valid !== 1'b0 || guess !== 4'd15) begin
      errors++;
      $display("FAIL lt_err: got err=%b done=%b steps=%0d gv=%b guess=%0d, want 1 0 5 0 15",
               err, done, steps, guess_valid, guess);
    end
    mode = 0;
  endtask

  task automatic test_patterns();
    logic [2:0] pats[3] = '{3'b110, 3'b000, 3'b101};
    for (int p = 0; p < 3; p++) begin
      do_reset();
      mode = 2; force_pat = pats[p]; secret = 4'd11;
      do_start();
      @(negedge clk);
      mode = 0;
      checks++;
`ifdef SAR_ONEHOT_CHECK_EN
      if (err !== 1'b1 || steps !== 3'd1 || guess_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL pat_%b: got err=%b steps=%0d gv=%b done=%b, want 1 1 0 0",
                 pats[p], err, steps, guess_valid, done);
      end
`else
      if (p == 0) begin
        if (guess_valid !== 1'b1 || guess !== 4'd11 || steps !== 3'd1 || err !== 1'b0) begin
          errors++;
          $display("FAIL pat_110: got gv=%b guess=%0d steps=%0d err=%b, want 1 11 1 0",
                   guess_valid, guess, steps, err);
        end
      end else if (p == 1) begin
        if (guess_valid !== 1'b1 || guess !== 4'd7 || steps !== 3'd0 || err !== 1'b0) begin
          errors++;
          $display("FAIL pat_000: got gv=%b guess=%0d steps=%0d err=%b, want 1 7 0 0",
                   guess_valid, guess, steps, err);
        end
      end else begin
        if (done !== 1'b1 || found !== 4'd7 || steps !== 3'd1 || err !== 1'b0) begin
          errors++;
          $display("FAIL pat_101: got done=%b found=%0d steps=%0d err=%b, want 1 7 1 0",
                   done, found, steps, err);
        end
      end
`endif
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    mode = 0; secret = 4'd5;
    do_start();
    repeat (2) @(negedge clk);
    checks++;
    if (steps !== 3'd2 || guess !== 4'd5 || guess_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: got steps=%0d guess=%0d gv=%b, want 2 5 1", steps, guess, guess_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (guess_valid !== 1'b0 || steps !== 3'd0 || guess !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got gv=%b steps=%0d guess=%0d done=%b, want 0 0 0 0",
               guess_valid, steps, guess, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmp_hold();
    mode = 0; secret = 4'd5;
    do_start();
    checks++;
    if (guess !== 4'd7) begin
      errors++;
      $display("FAIL hold_g0: got guess=%0d, want 7", guess);
    end
    @(negedge clk);
    cmp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (guess_valid !== 1'b1 || guess !== 4'd3 || steps !== 3'd1) begin
        errors++;
        $display("FAIL hold_c%0d: got gv=%b guess=%0d steps=%0d, want 1 3 1", i, guess_valid, guess, steps);
      end
    end
    cmp_en = 1'b1;
    @(negedge clk);
    checks++;
    if (guess !== 4'd5 || steps !== 3'd2) begin
      errors++;
      $display("FAIL hold_g2: got guess=%0d steps=%0d, want 5 2", guess, steps);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || found !== 4'd5 || steps !== 3'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL hold_result: got done=%b found=%0d steps=%0d err=%b, want 1 5 3 0",
               done, found, steps, err);
    end
  endtask

  initial begin
    test_reset();
    test_secret11();
    test_secret0();
    test_secret15();
    test_back_to_back();
    test_always_lt();
    test_patterns();
    test_reset_mid();
    test_cmp_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_guess_ctrl.md
Name: sar_guess_ctrl

Overview:
- Sequential binary-search controller that sits on the driving side of a WIDTH-bit magnitude comparator.
- It presents a candidate value `guess` and consumes the comparator's lt/gt/eq answer for `guess` vs. a hidden secret.
- It narrows the [lo, hi] bounds each step until it gets eq, then reports the found value and the step count.
- Used as the stimulus/search engine paired with the team's comparator blocks (guessing-game lab, SAR-style lookup).

Parameters:
- WIDTH, 4, operand width in bits. Search range is 0 .. 2^WIDTH-1.
- STEPW, 3, width of the step counter. Must hold WIDTH+1; 3 covers WIDTH<=6.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a search; honoured only in IDLE, DONE or ERR.
- guess  output  WIDTH  current candidate driven to comparator operand A.
- guess_valid  output  1  high while in PROBE; guess is stable.
- cmp_valid  input  1  comparator answer valid this cycle; sampled only in PROBE.
- cmp_lt  input  1  guess < secret.
- cmp_gt  input  1  guess > secret.
- cmp_eq  input  1  guess == secret.
- done  output  1  level, high in DONE until the next accepted start or reset.
- found  output  WIDTH  value for which eq was returned; valid while done.
- steps  output  STEPW  number of answers accepted in the current or last search.
- err  output  1  level, high in ERR until the next accepted start or reset.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE; lo=0; hi=2^WIDTH-1; guess=0; steps=0.
  - guess_valid, done and err are 0; found=0.
- States:
  - IDLE: start -> PROBE. On that edge: lo=0, hi=2^WIDTH-1, steps=0, done=0, err=0, guess=(lo+hi)>>1 using WIDTH+1-bit sum, i.e. 2^(WIDTH-1)-1.
  - PROBE, guess_valid=1:
    - cmp_valid=0: hold all registers.
    - cmp_valid=1: steps+1, then:
      - eq -> DONE, found=guess.
      - lt -> lo=guess+1, in WIDTH+1 bits.
      - gt -> hi=guess-1, in WIDTH+1 bits.
      - After lt/gt: if new lo>new hi, or gt at guess=0, or lt at guess=2^WIDTH-1 -> ERR (inconsistent answers). Otherwise stay in PROBE with guess=(new lo+new hi)>>1.
  - DONE: outputs held. start -> PROBE, same initialisation as from IDLE.
  - ERR: guess and steps held. start -> PROBE, same initialisation as from IDLE.
- Latency:
  - First guess is valid the cycle after start.
  - Each accepted answer produces the next guess, or DONE/ERR, on the following cycle.
  - Worst case is WIDTH+1 answers: 5 for WIDTH=4.
- start in PROBE is ignored; no abort.
- guess changes only on accepted answers or start; guess_valid falls on the same edge that enters DONE or ERR.
- rst_n low mid-search returns immediately to reset values; any partial result is discarded.
- steps saturates at 2^STEPW-1. This is unreachable with legal answers.

Optional Feature:
- Macro: SAR_ONEHOT_CHECK_EN.
- Defined: when cmp_valid=1, {cmp_lt,cmp_gt,cmp_eq} must be exactly one-hot. Any other pattern (000, 110, 111, ...) -> ERR, and steps still increments.
- Undefined: answers are decoded by priority eq > lt > gt. 000 with cmp_valid=1 is treated as not-valid: hold, no step increment.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, PROBE=2'd1, DONE=2'd2, ERR=2'd3;
  - default WIDTH;
  - the answer one-hot encoding LT=3'b100, GT=3'b010, EQ=3'b001.
- One sub-module, sar_bound_update: combinational next-lo/next-hi/next-guess plus the inconsistency flag. Inputs: lo, hi, guess, decoded answer.
- FSM and registers stay in sar_guess_ctrl.

Test Plan (WIDTH=4; bench comparator answers combinationally with cmp_valid=1 each PROBE cycle unless stated):
- Secret 11 -> guesses 7(lt), 11(eq); done=1, found=11, steps=2, err=0.
- Secret 0 -> guesses 7, 3, 1, 0; done with found=0, steps=4.
- Secret 15 -> guesses 7, 11, 13, 14, 15; steps=5, the worst case; done=1.
- Bench always answers lt -> guesses 7, 11, 13, 14, 15, then lt at 15 -> err=1, steps=5, done=0.
- With SAR_ONEHOT_CHECK_EN, answer 110 on first guess -> err=1, steps=1. Without the macro, same stimulus -> treated as lt, next guess=11.
- rst_n low during PROBE at steps=2 -> guess_valid=0, steps=0, state IDLE. Then start with secret 5 -> guesses 7, 3, 5; found=5, steps=3. cmp_valid held low for 3 cycles mid-search -> guess stable, steps unchanged.
